// File: rtl/wvb_overflow_log_fifo.sv
// Responder for the overflow-log req/ack handshake; stores {start, end} LTC pairs in an FWFT FIFO.
// Optional duration accumulator (total_ovfl_clks_o) is compiled in with WVB_OVFL_LOG_DURATION_EN.
module wvb_overflow_log_fifo #(
  parameter int unsigned P_LTC_WIDTH      = 48,
  parameter int unsigned P_DEPTH_LOG2     = 4,
  parameter int unsigned P_DROP_CNT_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        overflow_fifo_req_i,
  input  logic [P_LTC_WIDTH-1:0]      overflow_start_ltc_i,
  input  logic [P_LTC_WIDTH-1:0]      overflow_end_ltc_i,
  output logic                        overflow_fifo_ack_o,
  input  logic                        rd_ack_i,
  output logic [P_LTC_WIDTH-1:0]      rd_start_ltc_o,
  output logic [P_LTC_WIDTH-1:0]      rd_end_ltc_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [P_DEPTH_LOG2:0]       count_o,
  output logic [P_DROP_CNT_WIDTH-1:0] drop_cnt_o,
  input  logic                        drop_clr_i
`ifdef WVB_OVFL_LOG_DURATION_EN
  ,
  output logic [P_LTC_WIDTH-1:0]      total_ovfl_clks_o
`endif
);

  localparam int unsigned Depth  = 1 << P_DEPTH_LOG2;
  localparam int unsigned CntW   = P_DEPTH_LOG2 + 1;
  localparam int unsigned EntryW = 2 * P_LTC_WIDTH;

  localparam logic [CntW-1:0]             FullCnt = CntW'(Depth);
  localparam logic [CntW-1:0]             CntOne  = CntW'(1);
  localparam logic [P_DEPTH_LOG2-1:0]     PtrOne  = P_DEPTH_LOG2'(1);
  localparam logic [P_DROP_CNT_WIDTH-1:0] DropOne = P_DROP_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAck     = 2'd1,
    StRelease = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   ack_q, ack_d;
  logic   capture;

  logic [EntryW-1:0]       mem_q [Depth];
  logic [P_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [P_DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic full, empty, push, pop, drop;

  // Handshake FSM: one capture per req assertion, then wait for req low plus one idle cycle.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (overflow_fifo_req_i) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        if (!overflow_fifo_req_i) begin
          ack_d   = 1'b0;
          state_d = StRelease;
        end
      end
      StRelease: state_d = StIdle;
      default: begin
        ack_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // Full/empty come from the pre-edge count, so a pop never makes room for a same-cycle request.
  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  assign push  = capture & ~full;
  assign drop  = capture & full;
  assign pop   = rd_ack_i & ~empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr_i) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DropOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {overflow_start_ltc_i, overflow_end_ltc_i};
    end
  end

  logic [EntryW-1:0] head;
  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign rd_start_ltc_o      = head[EntryW-1:P_LTC_WIDTH];
  assign rd_end_ltc_o        = head[P_LTC_WIDTH-1:0];
  assign empty_o             = empty;
  assign full_o              = full;
  assign count_o             = count_q;
  assign drop_cnt_o          = drop_cnt_q;
  assign overflow_fifo_ack_o = ack_q;

`ifdef WVB_OVFL_LOG_DURATION_EN
  logic [P_LTC_WIDTH-1:0] cap_start_q, cap_end_q;
  logic                   acc_pend_q;
  logic [P_LTC_WIDTH-1:0] total_q, total_d;
  logic [P_LTC_WIDTH-1:0] dur;
  logic [P_LTC_WIDTH:0]   acc_sum;

  // Duration wraps modulo 2^P_LTC_WIDTH; the extra sum bit flags accumulator saturation.
  assign dur     = cap_end_q - cap_start_q;
  assign acc_sum = {1'b0, total_q} + {1'b0, dur};

  always_comb begin
    total_d = total_q;
    if (drop_clr_i) begin
      total_d = '0;
    end else if (acc_pend_q) begin
      total_d = acc_sum[P_LTC_WIDTH] ? '1 : acc_sum[P_LTC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_start_q <= '0;
      cap_end_q   <= '0;
      acc_pend_q  <= 1'b0;
      total_q     <= '0;
    end else begin
      acc_pend_q <= capture;
      total_q    <= total_d;
      if (capture) begin
        cap_start_q <= overflow_start_ltc_i;
        cap_end_q   <= overflow_end_ltc_i;
      end
    end
  end

  assign total_ovfl_clks_o = total_q;
`endif

endmodule

// File: tb/tb_wvb_overflow_log_fifo.sv
// Self-checking bench: directed handshake scenarios followed by randomized traffic,
// compared against a queue-based model of the logged entries and counters.
module tb_wvb_overflow_log_fifo;

  localparam int unsigned LtcW      = 48;
  localparam int unsigned DepthLog2 = 4;
  localparam int unsigned DropW     = 4;
  localparam int unsigned Depth     = 1 << DepthLog2;
  localparam int unsigned DropMax   = (1 << DropW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req;
  logic [LtcW-1:0]      st_ltc;
  logic [LtcW-1:0]      en_ltc;
  logic                 ack;
  logic                 rd_ack;
  logic [LtcW-1:0]      rd_start;
  logic [LtcW-1:0]      rd_end;
  logic                 empty;
  logic                 full;
  logic [DepthLog2:0]   count;
  logic [DropW-1:0]     drop_cnt;
  logic                 drop_clr;
`ifdef WVB_OVFL_LOG_DURATION_EN
  logic [LtcW-1:0]      total;
`endif

  wvb_overflow_log_fifo #(
    .P_LTC_WIDTH      (LtcW),
    .P_DEPTH_LOG2     (DepthLog2),
    .P_DROP_CNT_WIDTH (DropW)
  ) u_dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .overflow_fifo_req_i  (req),
    .overflow_start_ltc_i (st_ltc),
    .overflow_end_ltc_i   (en_ltc),
    .overflow_fifo_ack_o  (ack),
    .rd_ack_i             (rd_ack),
    .rd_start_ltc_o       (rd_start),
    .rd_end_ltc_o         (rd_end),
    .empty_o              (empty),
    .full_o               (full),
    .count_o              (count),
    .drop_cnt_o           (drop_cnt),
    .drop_clr_i           (drop_clr)
`ifdef WVB_OVFL_LOG_DURATION_EN
    ,
    .total_ovfl_clks_o    (total)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: logged entries in arrival order plus the two counters.
  logic [2*LtcW-1:0] q_model [$];
  int unsigned       drop_model;
  logic [LtcW-1:0]   total_model;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    logic [2*LtcW-1:0] h;
    check_eq({tag, ".count"}, 96'(count), 96'(q_model.size()));
    check_eq({tag, ".empty"}, 96'(empty), 96'(q_model.size() == 0));
    check_eq({tag, ".full"}, 96'(full), 96'(q_model.size() == Depth));
    check_eq({tag, ".drop"}, 96'(drop_cnt), 96'(drop_model));
    if (q_model.size() > 0) begin
      h = q_model[0];
      check_eq({tag, ".head_start"}, 96'(rd_start), 96'(h[2*LtcW-1:LtcW]));
      check_eq({tag, ".head_end"}, 96'(rd_end), 96'(h[LtcW-1:0]));
    end
`ifdef WVB_OVFL_LOG_DURATION_EN
    check_eq({tag, ".total"}, 96'(total), 96'(total_model));
`endif
  endtask

  task automatic model_capture(input logic [LtcW-1:0] s, input logic [LtcW-1:0] e,
                               input bit do_pop, input bit clr);
    bit              was_full;
    bit              was_empty;
    logic [LtcW-1:0] diff;
    logic [LtcW:0]   sum;
    was_full  = (q_model.size() == Depth);
    was_empty = (q_model.size() == 0);
    if (do_pop && !was_empty) void'(q_model.pop_front());
    if (!was_full) q_model.push_back({s, e});
    if (clr) drop_model = 0;
    else if (was_full && drop_model != DropMax) drop_model++;
    if (clr) total_model = '0;
    diff = e - s;
    sum  = {1'b0, total_model} + {1'b0, diff};
    total_model = sum[LtcW] ? '1 : sum[LtcW-1:0];
  endtask

  task automatic handshake(input logic [LtcW-1:0] s, input logic [LtcW-1:0] e, input int hold,
                           input bit do_pop, input bit clr, input string tag);
    req      = 1'b1;
    st_ltc   = s;
    en_ltc   = e;
    rd_ack   = do_pop;
    drop_clr = clr;
    step();
    rd_ack   = 1'b0;
    drop_clr = 1'b0;
    model_capture(s, e, do_pop, clr);
    check_eq({tag, ".ack_rise"}, 96'(ack), 96'(1));
    for (int i = 0; i < hold; i++) begin
      step();
      if (i == hold - 1) check_eq({tag, ".ack_hold"}, 96'(ack), 96'(1));
    end
    req = 1'b0;
    step();
    check_eq({tag, ".ack_fall"}, 96'(ack), 96'(0));
    step();
    check_state(tag);
  endtask

  task automatic pop_op(input string tag);
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    if (q_model.size() > 0) void'(q_model.pop_front());
    check_state(tag);
  endtask

  task automatic reset_dut(input string tag);
    rst      = 1'b1;
    req      = 1'b0;
    rd_ack   = 1'b0;
    drop_clr = 1'b0;
    step();
    rst = 1'b0;
    q_model.delete();
    drop_model  = 0;
    total_model = '0;
    check_eq({tag, ".ack"}, 96'(ack), 96'(0));
    check_state(tag);
  endtask

  initial begin
    logic [63:0]     r64;
    logic [LtcW-1:0] rs;
    logic [LtcW-1:0] re;
    int              op;

    rst      = 1'b1;
    req      = 1'b0;
    st_ltc   = '0;
    en_ltc   = '0;
    rd_ack   = 1'b0;
    drop_clr = 1'b0;
    q_model.delete();
    drop_model  = 0;
    total_model = '0;
    step();
    step();
    rst = 1'b0;
    check_eq("reset.ack", 96'(ack), 96'(0));
    check_eq("reset.rd_start", 96'(rd_start), 96'(0));
    check_eq("reset.rd_end", 96'(rd_end), 96'(0));
    check_state("reset");

    handshake(48'h100, 48'h180, 0, 1'b0, 1'b0, "single");
    pop_op("single_pop");
    handshake(48'h200, 48'h280, 20, 1'b0, 1'b0, "hold20");
    pop_op("hold20_pop");

    for (int i = 0; i < Depth; i++) handshake(LtcW'(i), LtcW'(i + 10), 0, 1'b0, 1'b0, "fill");
    handshake(48'h77, 48'h99, 0, 1'b0, 1'b0, "drop17");
    for (int i = 0; i < 16; i++) handshake(48'h5, 48'h6, 0, 1'b0, 1'b0, "drop_sat");
    for (int i = 0; i < Depth; i++) pop_op("drain");

    pop_op("pop_empty");
    handshake(48'hABC, 48'hDEF, 1, 1'b0, 1'b0, "after_empty");
    pop_op("after_empty_pop");

    for (int i = 0; i < 3; i++) handshake(LtcW'(i + 32), LtcW'(i + 40), 0, 1'b0, 1'b0, "three");
    handshake(48'h123, 48'h456, 0, 1'b1, 1'b0, "simul");
    for (int i = 0; i < 13; i++) handshake(LtcW'(i), LtcW'(i), 0, 1'b0, 1'b0, "refill");
    handshake(48'h1, 48'h2, 0, 1'b0, 1'b0, "full_drop");
    handshake(48'h1, 48'h2, 0, 1'b0, 1'b1, "clr_drop");
    handshake(48'h1, 48'h2, 0, 1'b1, 1'b0, "full_pop_drop");

    reset_dut("reset2");
    handshake(48'h100, 48'h180, 0, 1'b0, 1'b0, "dur_a");
    handshake(48'hFFFF_FFFF_FFF0, 48'h10, 0, 1'b0, 1'b0, "dur_wrap");
    handshake(48'h0, 48'hFFFF_FFFF_FFFF, 0, 1'b0, 1'b0, "dur_sat");

    req    = 1'b1;
    st_ltc = 48'h10;
    en_ltc = 48'h20;
    step();
    check_eq("mid_ack.ack", 96'(ack), 96'(1));
    step();
    reset_dut("mid_ack_reset");

    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        r64 = {$urandom, $urandom};
        rs  = r64[LtcW-1:0];
        if ($urandom_range(0, 1) == 1) begin
          re = rs + LtcW'($urandom_range(0, 4096));
        end else begin
          r64 = {$urandom, $urandom};
          re  = r64[LtcW-1:0];
        end
        handshake(rs, re, int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0), "rand_hs");
      end else if (op <= 7) begin
        pop_op("rand_pop");
      end else if (op == 8) begin
        drop_clr = 1'b1;
        step();
        drop_clr    = 1'b0;
        drop_model  = 0;
        total_model = '0;
        check_state("rand_clr");
      end else begin
        step();
        check_state("rand_idle");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wvb_overflow_log_fifo.md
Name: wvb_overflow_log_fifo

Overview:
- Responder end of the waveform-buffer overflow logging handshake.
- Each overflow controller raises a request that carries an overflow start LTC and end LTC.
- This block accepts the request with a four-phase req/ack handshake and stores the {start, end} pair in a small FWFT FIFO.
- The FIFO is exposed to the register/readout side, with a drop counter and occupancy.

Parameters:
- P_LTC_WIDTH, 48: width of each LTC timestamp.
- P_DEPTH_LOG2, 4: log2 of FIFO entry count (16 entries).
- P_DROP_CNT_WIDTH, 16: width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- overflow_fifo_req  in  1  four-phase request from the overflow controller
- overflow_start_ltc  in  P_LTC_WIDTH  overflow start time; valid while req high
- overflow_end_ltc  in  P_LTC_WIDTH  overflow end time; valid while req high
- overflow_fifo_ack  out  1  four-phase acknowledge (registered)
- rd_ack  in  1  pop-head pulse from the readout side
- rd_start_ltc  out  P_LTC_WIDTH  head entry start LTC (FWFT)
- rd_end_ltc  out  P_LTC_WIDTH  head entry end LTC (FWFT)
- empty  out  1  FIFO holds no entries
- full  out  1  FIFO holds 2^P_DEPTH_LOG2 entries
- count  out  P_DEPTH_LOG2+1  entries stored
- drop_cnt  out  P_DROP_CNT_WIDTH  requests acked but not stored because the FIFO was full
- drop_clr  in  1  synchronous clear of drop_cnt (and of the total accumulator when the optional feature is compiled in)

Behaviour:
- Reset values: overflow_fifo_ack=0, empty=1, full=0, count=0, drop_cnt=0, rd_*_ltc=0, FSM=S_IDLE. Reset mid-handshake returns to S_IDLE with ack=0 on the next cycle.
- FSM states: S_IDLE=0, S_ACK=1, S_RELEASE=2.
- S_IDLE:
  - If req=1, capture start/end LTC.
  - If !full: write the entry. Otherwise: drop_cnt++, saturating at all-ones.
  - Set ack<=1 and go to S_ACK. Ack is visible one cycle after req is first sampled high.
- S_ACK: hold ack=1. When req=0, set ack<=0 and go to S_RELEASE.
- S_RELEASE: one idle cycle, then S_IDLE. This guarantees req is resampled only after ack has been low for at least one cycle.
- Exactly one entry is stored (or dropped) per handshake. req held high in S_ACK never causes a second write.
- Full is evaluated before any same-cycle pop. A request arriving while full is dropped even if rd_ack pops in the same cycle.
- FIFO:
  - Circular RAM/regs, 2*P_LTC_WIDTH bits per entry.
  - Write and read pointers are P_DEPTH_LOG2 bits and wrap modulo depth.
  - count = wr-rd tracking with an extra bit, so full is distinguishable.
- FWFT: when !empty, rd_start_ltc/rd_end_ltc present the head entry combinationally from storage (registered-out acceptable if head is valid the cycle empty deasserts).
- Pop on rd_ack while empty is ignored (count stays 0, no underflow).
- Simultaneous write and pop while not full and not empty: count unchanged, both pointers advance.
- Write into an empty FIFO: empty deasserts one cycle after the write edge; the head shows the new entry in that same cycle.
- drop_clr takes priority over a same-cycle drop increment.

Optional Feature:
- Macro: WVB_OVFL_LOG_DURATION_EN.
- When defined:
  - Adds output total_ovfl_clks (P_LTC_WIDTH).
  - On each handshake, stored or dropped, total_ovfl_clks += (end_ltc - start_ltc), modulo-P_LTC_WIDTH subtraction. The accumulation saturates at all-ones.
  - Reset value is 0; drop_clr clears it.
  - The accumulator updates one cycle after capture.
- When undefined: the port and the logic are absent; all other behaviour is identical.

Test Plan:
- Single handshake: req=1 with start=0x100, end=0x180 → ack=1 next cycle. Drop req → ack=0 next cycle. Then empty=0, count=1, rd_start=0x100, rd_end=0x180.
- Req held high 20 cycles → exactly one entry, count=1, ack stays 1 until req falls.
- Fill: 16 handshakes with start=i, end=i+10 → full=1, count=16. Handshake 17 is acked and drop_cnt=1. Pop 16 times and read back start=0..15 in order, then empty=1.
- Pop on empty: rd_ack pulse at count=0 → count stays 0, empty=1, pointers unchanged. Subsequent write reads back correctly.
- Simultaneous: count=3, handshake write coincident with rd_ack → count stays 3, head advances. drop_clr asserted the same cycle as a full-drop → drop_cnt=0.
- With WVB_OVFL_LOG_DURATION_EN: entries (0x100,0x180) and (0xFFFF_FFFF_FFF0,0x10) → total_ovfl_clks=0x80+0x20=0xA0. Reset mid-S_ACK → ack=0, count=0, total=0.
